// File: rtl/div_serial_frame.sv
// Serial LSB-first operand loader and result streamer wrapped around a 20-bit combinational divider.
// Optional macro DIV_ZERO_TRAP_EN: zero divisor yields q = all-ones, r = dividend, and pulses div_zero.
module div_serial_frame #(
  parameter int WIDTH  = 20,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             busy,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_SETTLE,
    S_CAPTURE,
    S_SHIFT_Q,
    S_SHIFT_R
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [3:0]           settle_q, settle_d;
  logic [WIDTH-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [2*WIDTH-1:0]   sr_q, sr_d;
  logic                 busy_q, busy_d;
  logic                 in_fire, out_fire, last_bit;
  logic [2*WIDTH-1:0]   capture_word;

  assign in_ready     = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign out_valid    = (state_q == S_SHIFT_Q) || (state_q == S_SHIFT_R);
  assign out_bit      = sr_q[0];
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign busy         = busy_q;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;
  assign last_bit     = (cnt_q == 5'(WIDTH-1));

`ifdef DIV_ZERO_TRAP_EN
  logic zero_trap;
  assign zero_trap    = (divisor_q == '0);
  assign capture_word = zero_trap ? {dividend_q, {WIDTH{1'b1}}}
                                  : {div_remainder, div_quotient};
  assign div_zero     = (state_q == S_CAPTURE) && zero_trap;
`else
  assign capture_word = {div_remainder, div_quotient};
  assign div_zero     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sr_d       = sr_q;
    case (state_q)
      S_LOAD_A: begin
        if (in_fire) begin
          dividend_d = {in_bit, dividend_q[WIDTH-1:1]};
          if (last_bit) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (in_fire) begin
          divisor_d = {in_bit, divisor_q[WIDTH-1:1]};
          if (last_bit) begin
            state_d  = S_SETTLE;
            cnt_d    = '0;
            settle_d = 4'(SETTLE - 1);
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      // Stays SETTLE cycles: the counter is preloaded with SETTLE-1 on entry.
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        sr_d    = capture_word;
        cnt_d   = '0;
        state_d = S_SHIFT_Q;
      end
      S_SHIFT_Q, S_SHIFT_R: begin
        if (out_fire) begin
          sr_d = {1'b0, sr_q[2*WIDTH-1:1]};
          if (last_bit) begin
            cnt_d   = '0;
            state_d = (state_q == S_SHIFT_Q) ? S_SHIFT_R : S_LOAD_A;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = S_LOAD_A;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_LOAD_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD_A;
      cnt_q      <= '0;
      settle_q   <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sr_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sr_q       <= sr_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_serial_frame.sv
// Directed, table-driven bench for div_serial_frame with a behavioural divider model on the parallel side.
module tb_div_serial_frame;
  localparam int WIDTH  = 20;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_bit, in_ready;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic             out_valid, out_bit, out_ready, busy, div_zero;

  int checks   = 0;
  int failures = 0;
  int dz_cnt   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    int               dz;
  } vec_t;
  vec_t tv [6];

  div_serial_frame #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .busy(busy), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Divider stand-in: true division, fixed marker values for a zero divisor.
  assign div_quotient  = (div_divisor != 0) ? div_dividend / div_divisor : 20'hABCDE;
  assign div_remainder = (div_divisor != 0) ? div_dividend % div_divisor : 20'h13579;

  always @(negedge clk) if (rst_n && div_zero) dz_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps);
    for (int i = 0; i < WIDTH; i++) begin
      int  guard;
      bit  acc;
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_bit   = w[i];
      guard    = 0;
      acc      = 1'b0;
      while (!acc && guard < 100) begin
        acc = in_ready;
        tick();
        guard++;
      end
      if (!acc) check("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic run_frame(input int idx, input bit gaps, input bit stall, input bit hold_in);
    logic [39:0] res;
    int          lat, dz0;
    logic        b0;
    send_word(tv[idx].a, gaps);
    send_word(tv[idx].b, gaps);
    check($sformatf("dividend_f%0d", idx), 40'(div_dividend), 40'(tv[idx].a));
    check($sformatf("divisor_f%0d", idx), 40'(div_divisor), 40'(tv[idx].b));
    dz0 = dz_cnt;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check($sformatf("latency_f%0d", idx), 40'(lat), 40'(SETTLE + 1));
    check($sformatf("busy_out_f%0d", idx), 40'(busy), 40'd1);
    check($sformatf("in_ready_out_f%0d", idx), 40'(in_ready), 40'd0);
    if (hold_in) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
    end
    res = '0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (stall && i == 25) begin
        out_ready = 1'b0;
        b0 = out_bit;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("stall_bit_frozen", 40'(out_bit), 40'(b0));
          check("stall_valid_held", 40'(out_valid), 40'd1);
        end
        out_ready = 1'b1;
      end
      wait_valid();
      if (i == 2 * WIDTH - 1) check("in_ready_last_xfer", 40'(in_ready), 40'd0);
      res[i] = out_bit;
      tick();
    end
    in_valid = 1'b0;
    check($sformatf("quotient_f%0d", idx), 40'(res[19:0]), 40'(tv[idx].q));
    check($sformatf("remainder_f%0d", idx), 40'(res[39:20]), 40'(tv[idx].r));
    check($sformatf("div_zero_f%0d", idx), 40'(dz_cnt - dz0), 40'(tv[idx].dz));
    check($sformatf("in_ready_after_f%0d", idx), 40'(in_ready), 40'd1);
    check($sformatf("out_valid_after_f%0d", idx), 40'(out_valid), 40'd0);
    check($sformatf("busy_after_f%0d", idx), 40'(busy), 40'd0);
    if (hold_in) check("dividend_held_during_out", 40'(div_dividend), 40'(tv[idx].a));
  endtask

  initial begin
    tv[0] = '{a: 20'h00064, b: 20'h00007, q: 20'h0000E, r: 20'h00002, dz: 0};
    tv[1] = '{a: 20'hFFFFF, b: 20'h00003, q: 20'h55555, r: 20'h00000, dz: 0};
`ifdef DIV_ZERO_TRAP_EN
    tv[2] = '{a: 20'h12345, b: 20'h00000, q: 20'hFFFFF, r: 20'h12345, dz: 1};
`else
    tv[2] = '{a: 20'h12345, b: 20'h00000, q: 20'hABCDE, r: 20'h13579, dz: 0};
`endif
    tv[3] = '{a: 20'h00005, b: 20'h00009, q: 20'h00000, r: 20'h00005, dz: 0};
    tv[4] = '{a: 20'hFFFFF, b: 20'h00001, q: 20'hFFFFF, r: 20'h00000, dz: 0};
    tv[5] = '{a: 20'hABCDE, b: 20'h00100, q: 20'h00ABC, r: 20'h000DE, dz: 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 40'(in_ready), 40'd1);
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_out_bit", 40'(out_bit), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_div_zero", 40'(div_zero), 40'd0);
    check("rst_dividend", 40'(div_dividend), 40'd0);
    check("rst_divisor", 40'(div_divisor), 40'd0);

    for (int i = 0; i < 6; i++) run_frame(i, (i % 2) == 1, i == 1, 1'b0);

    // Abort while the 7th quotient bit is being presented.
    send_word(tv[5].a, 1'b0);
    send_word(tv[5].b, 1'b0);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      wait_valid();
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 40'(out_valid), 40'd0);
    check("abort_in_ready", 40'(in_ready), 40'd1);
    check("abort_busy", 40'(busy), 40'd0);
    check("abort_dividend", 40'(div_dividend), 40'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_abort_in_ready", 40'(in_ready), 40'd1);
    check("post_abort_out_valid", 40'(out_valid), 40'd0);
    run_frame(3, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames, with input held active during the first frame's output.
    run_frame(0, 1'b0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_serial_frame.md
# div_serial_frame

Bit-serial front/back end for the combinational 20-bit parallel divider. Assembles a dividend and a divisor from a serial LSB-first stream and presents them to the divider as stable parallel words. After a fixed settle interval it captures quotient and remainder and streams them back out LSB-first under a valid/ready handshake. It sits between the serial data bus and the divider stage.

## Interface
- WIDTH, 20: word width; fixed to the divider width (only 20 supported).
- SETTLE, 2: clock cycles the divider inputs are held stable before capture (1..15).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit carries a valid operand bit.
- in_bit  in  1  serial operand bit, LSB first; dividend word, then divisor word.
- in_ready  out  1  block accepts an operand bit this cycle.
- div_dividend  out  WIDTH  registered dividend to the divider.
- div_divisor  out  WIDTH  registered divisor to the divider.
- div_quotient  in  WIDTH  quotient from the divider.
- div_remainder  in  WIDTH  remainder from the divider.
- out_valid  out  1  out_bit carries a valid result bit.
- out_bit  out  1  serial result bit, LSB first; quotient word, then remainder word.
- out_ready  in  1  downstream accepts out_bit this cycle.
- busy  out  1  high in any state other than LOAD_A.
- div_zero  out  1  one-cycle pulse on capture of a zero divisor (see Configuration).

## Operation
- States: LOAD_A, LOAD_B, SETTLE, CAPTURE, SHIFT_Q, SHIFT_R. The reset state is LOAD_A.
- in_ready = 1 in LOAD_A and LOAD_B, and 0 otherwise. An input bit transfers when in_valid & in_ready.
- The bit counter is 5 bits, counting 0..WIDTH-1. It clears on every state change and never wraps past WIDTH-1.
- LOAD_A: each accepted bit shifts into div_dividend at the MSB; the register shifts right. After the 20th bit, bit 0 holds the first bit received. The 20th accepted bit moves the FSM to LOAD_B.
- LOAD_B: operates the same way into div_divisor. The 20th bit moves the FSM to SETTLE.
- div_dividend and div_divisor are held constant from the end of LOAD_B until the next LOAD_A acceptance.
- SETTLE: a down-counter counts SETTLE cycles, then the FSM moves to CAPTURE.
- CAPTURE: a single cycle. It loads the 40-bit output shift register with {div_remainder, div_quotient} and moves to SHIFT_Q.
- SHIFT_Q / SHIFT_R: out_valid = 1 and out_bit = shift register bit 0.
  - On out_valid & out_ready, the register shifts right and the counter advances.
  - After 20 transfers, SHIFT_Q moves to SHIFT_R.
  - After 20 transfers, SHIFT_R moves to LOAD_A.
- Stalls:
  - When in_valid is low, the input counter and input registers hold.
  - When out_ready is low, out_bit, the shift register and the counter hold.
- Inputs are ignored outside LOAD_A and LOAD_B.

## Timing
- Reset values (asserted asynchronously while rst_n is low):
  - State = LOAD_A.
  - div_dividend = 0 and div_divisor = 0.
  - Output shift register = 0 and counters = 0.
  - in_ready = 1, out_valid = 0, out_bit = 0, busy = 0, div_zero = 0.
- Reset mid-operation in any state aborts the operation. No partial result is emitted.
- Latency, assuming no stalls:
  - Edge N accepts the last divisor bit.
  - The FSM is in SETTLE for edges N+1..N+SETTLE.
  - CAPTURE occurs at edge N+SETTLE+1.
  - The first out_valid is high after edge N+SETTLE+1, and the first out_bit is available in the cycle after CAPTURE.
- The final output transfer and the first in_ready cannot coincide: in_ready rises in the cycle after the last SHIFT_R transfer.
- busy is registered from the state and is high from the first LOAD_B cycle through the last SHIFT_R cycle.

## Configuration
- DIV_ZERO_TRAP_EN defined:
  - In CAPTURE, if div_divisor == 0, the shift register loads quotient = 20'hFFFFF and remainder = div_dividend, not the divider outputs.
  - div_zero pulses high for the CAPTURE cycle.
- Not defined: divider outputs are always captured unchanged, and div_zero is tied to 0.

## Test plan
- Reset/idle: hold rst_n low, then release → in_ready = 1, out_valid = 0, busy = 0, div_dividend = div_divisor = 0.
- Basic frame, divider stubbed to q = 20'h0000E, r = 20'h00002: stream 20'h00064 then 20'h00007 LSB-first with no gaps.
  - div_dividend = 20'h00064 and div_divisor = 20'h00007 after the 40th bit.
  - out_valid rises SETTLE+1 edges later.
  - The 40 out bits are 0,1,1,1,0… (the quotient LSB-first), followed by the remainder LSB-first.
- Stalls: toggle in_valid at random and hold out_ready low for 5 cycles mid-SHIFT_R → identical bit sequence; out_bit is frozen while stalled.
- Divide by zero: dividend 20'h12345, divisor 0. With DIV_ZERO_TRAP_EN, the bench checks that:
  - div_zero pulses once;
  - the output is quotient 20'hFFFFF and remainder 20'h12345.
  - Without the macro, the stub values pass through and div_zero stays 0.
- Reset mid-operation: drop rst_n on the 7th SHIFT_Q bit → out_valid falls immediately; after release the state is LOAD_A with in_ready = 1, and a following frame completes correctly.
- Back-to-back: two frames (100/7, then 20'hFFFFF/20'h00003) → the second frame loads only after the first frame's 40th output transfer, and both results are correct.
